// File: rtl/camera_capture.sv
// DVP-style camera capture: samples vsync/href/din on PCLK, packs bus beats into pixels
// and writes them densely into a frame BRAM, with optional 2:1 decimation and frame sequencing.
module camera_capture #(
    parameter int unsigned COLS          = 640,
    parameter int unsigned ROWS          = 480,
    parameter int unsigned DIN_W         = 8,
    parameter int unsigned BYTES_PER_PIX = 2,
    parameter int unsigned ADDR_W        = 19
) (
    input  logic                             PCLK,
    input  logic                             reset,
    input  logic                             enable,
    input  logic                             decim,
    input  logic                             vsync,
    input  logic                             href,
    input  logic [DIN_W-1:0]                 din,
    output logic [ADDR_W-1:0]                waddr,
    output logic [DIN_W*BYTES_PER_PIX-1:0]   wdata,
    output logic                             we,
    output logic                             frame_done,
    output logic [15:0]                      frame_cnt,
    output logic                             line_err,
    output logic                             busy
);

    localparam int unsigned PIX_W  = DIN_W * BYTES_PER_PIX;
    localparam int unsigned BIDX_W = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;
    localparam logic [BIDX_W-1:0] LAST_BEAT = BIDX_W'(BYTES_PER_PIX - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);
    localparam logic [15:0]       COLS_W    = 16'(COLS);
    localparam logic [15:0]       ROWS_W    = 16'(ROWS);

    typedef enum logic [0:0] {StIdle, StCapture} state_t;

    state_t              state;
    logic                vsync_r, href_r, vsync_q, href_q;
    logic [DIN_W-1:0]    din_r;
    logic [15:0]         col, row;
    logic [BIDX_W-1:0]   byte_idx;
    logic [ADDR_W-1:0]   wcnt;
    logic                decim_l;
    logic [PIX_W-1:0]    pix_next;

    logic vs_fall, vs_rise, href_fall, frame_start, store;

    // Pins are sampled once; edges are detected on the sampled copies, so every
    // decision sees a stable, already-registered view of the sensor bus.
    assign vs_fall     = vsync_q & ~vsync_r;
    assign vs_rise     = ~vsync_q & vsync_r;
    assign href_fall   = href_q & ~href_r;
    assign frame_start = vs_fall & enable;
    assign store       = (col < COLS_W) && (row < ROWS_W) && (!decim_l || (!col[0] && !row[0]));

    generate
        if (BYTES_PER_PIX == 1) begin : g_single
            assign pix_next = din_r;
        end else begin : g_multi
            logic [PIX_W-DIN_W-1:0] sr;
            always_ff @(posedge PCLK) begin
                if (reset) begin
                    sr <= '0;
                end else if (state == StCapture && href_r) begin
                    sr <= pix_next[PIX_W-DIN_W-1:0];
                end
            end
            // Earlier beats sit above the newest one, so the first beat lands in the MSBs.
            assign pix_next = {sr, din_r};
        end
    endgenerate

    always_ff @(posedge PCLK) begin
        if (reset) begin
            state      <= StIdle;
            vsync_r    <= 1'b0;
            href_r     <= 1'b0;
            din_r      <= '0;
            vsync_q    <= 1'b0;
            href_q     <= 1'b0;
            col        <= '0;
            row        <= '0;
            byte_idx   <= '0;
            wcnt       <= '0;
            decim_l    <= 1'b0;
            waddr      <= '0;
            wdata      <= '0;
            we         <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            line_err   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            vsync_r    <= vsync;
            href_r     <= href;
            din_r      <= din;
            vsync_q    <= vsync_r;
            href_q     <= href_r;
            we         <= 1'b0;
            frame_done <= 1'b0;

            if (frame_start) begin
                state    <= StCapture;
                busy     <= 1'b1;
                col      <= '0;
                row      <= '0;
                byte_idx <= '0;
                wcnt     <= '0;
                line_err <= 1'b0;
                decim_l  <= decim;
            end else if (state == StCapture) begin
                if (vs_fall) begin
                    // Continuous mode ends here when enable was dropped between frames.
                    state <= StIdle;
                    busy  <= 1'b0;
                end else begin
                    if (href_r) begin
                        if (byte_idx == LAST_BEAT) begin
                            byte_idx <= '0;
                            if (col != 16'hFFFF) col <= col + 16'd1;
                            if (store) begin
                                we    <= 1'b1;
                                wdata <= pix_next;
                                waddr <= wcnt;
                                if (wcnt != LAST_ADDR) wcnt <= wcnt + 1'b1;
                            end
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                        end
                    end
                    if (href_fall) begin
                        if (row != 16'hFFFF) row <= row + 16'd1;
                        if (col != COLS_W || byte_idx != '0) line_err <= 1'b1;
                        col      <= '0;
                        byte_idx <= '0;
                    end
                    if (vs_rise) begin
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 16'd1;
                        if (!enable) begin
                            state <= StIdle;
                            busy  <= 1'b0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_camera_capture.sv
// Directed bench for camera_capture: a scoreboard queue of expected writes is filled as
// sensor beats are driven and drained by a monitor whenever the DUT strobes we.
module tb_camera_capture;

    localparam int unsigned COLS = 4;
    localparam int unsigned ROWS = 3;

    logic        PCLK = 1'b0;
    logic        reset, enable, decim, vsync, href;
    logic [7:0]  din;
    logic [3:0]  waddr;
    logic [15:0] wdata;
    logic        we, frame_done, line_err, busy;
    logic [15:0] frame_cnt;

    typedef struct {
        logic [3:0]  a;
        logic [15:0] d;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   m_addr = 0;
    int   done_cnt = 0;
    int   max_addr = 0;
    int   exp_fc = 0;

    camera_capture #(
        .COLS(COLS), .ROWS(ROWS), .DIN_W(8), .BYTES_PER_PIX(2), .ADDR_W(4)
    ) dut (
        .PCLK(PCLK), .reset(reset), .enable(enable), .decim(decim), .vsync(vsync),
        .href(href), .din(din), .waddr(waddr), .wdata(wdata), .we(we),
        .frame_done(frame_done), .frame_cnt(frame_cnt), .line_err(line_err), .busy(busy)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge PCLK) begin
        if (frame_done) done_cnt++;
        if (we) begin
            if (int'(waddr) > max_addr) max_addr = int'(waddr);
            if (q.size() == 0) begin
                check("unexpected_we", 32'(we), 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("waddr", 32'(waddr), 32'(e.a));
                check("wdata", 32'(wdata), 32'(e.d));
            end
        end
    end

    task automatic step();
        @(posedge PCLK);
        #2;
    endtask

    task automatic send_line(input int len, input int row, input bit cap, input bit dec,
                             inout int b);
        logic [7:0] hi;
        int         col;
        exp_t       e;
        col = 0;
        hi  = '0;
        for (int i = 0; i < len; i++) begin
            href = 1'b1;
            din  = b[7:0];
            if (i % 2 == 0) begin
                hi = b[7:0];
            end else begin
                if (cap && col < COLS && row < ROWS && (!dec || (col % 2 == 0 && row % 2 == 0)))
                begin
                    e.a = m_addr[3:0];
                    e.d = {hi, b[7:0]};
                    q.push_back(e);
                    m_addr++;
                end
                col++;
            end
            b++;
            step();
        end
        href = 1'b0;
        repeat (3) step();
    endtask

    task automatic run_frame(input string tag, input int nlines, input int nbytes,
                             input int short_line, input int short_len, input int drop_line,
                             input bit cap, input bit dec, input bit exp_err);
        int b;
        int start_done;
        b          = 0;
        decim      = dec;
        start_done = done_cnt;
        vsync = 1'b1;
        repeat (4) step();
        vsync = 1'b0;
        repeat (4) step();
        if (cap) begin
            m_addr = 0;
            check({tag, "_err_clr"}, 32'(line_err), 32'd0);
        end
        for (int l = 0; l < nlines; l++) begin
            if (l == drop_line) enable = 1'b0;
            send_line((l == short_line) ? short_len : nbytes, l, cap, dec, b);
        end
        vsync = 1'b1;
        repeat (4) step();
        if (cap) exp_fc++;
        check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_fc[15:0]));
        check({tag, "_done_pulses"}, 32'(done_cnt - start_done), cap ? 32'd1 : 32'd0);
        check({tag, "_pending"}, 32'(q.size()), 32'd0);
        check({tag, "_line_err"}, 32'(line_err), 32'(exp_err));
    endtask

    initial begin
        int b;
        reset  = 1'b1;
        enable = 1'b0;
        decim  = 1'b0;
        vsync  = 1'b0;
        href   = 1'b0;
        din    = '0;
        repeat (3) step();
        @(negedge PCLK);
        check("rst_waddr", 32'(waddr), 32'd0);
        check("rst_wdata", 32'(wdata), 32'd0);
        check("rst_we", 32'(we), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_line_err", 32'(line_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        step();
        reset  = 1'b0;
        enable = 1'b1;
        step();

        run_frame("clean", 3, 8, -1, 0, -1, 1'b1, 1'b0, 1'b0);
        run_frame("decim", 3, 8, -1, 0, -1, 1'b1, 1'b1, 1'b0);
        run_frame("short", 3, 8, 1, 7, -1, 1'b1, 1'b0, 1'b1);
        run_frame("recover", 3, 8, -1, 0, -1, 1'b1, 1'b0, 1'b0);
        max_addr = 0;
        run_frame("overlong", 5, 12, -1, 0, -1, 1'b1, 1'b0, 1'b1);
        check("overlong_max_addr", 32'(max_addr), 32'd11);

        enable = 1'b0;
        run_frame("ignored1", 3, 8, -1, 0, -1, 1'b0, 1'b0, 1'b1);
        check("ignored1_busy", 32'(busy), 32'd0);
        enable = 1'b1;
        run_frame("dropped", 3, 8, -1, 0, 1, 1'b1, 1'b0, 1'b0);
        run_frame("ignored2", 3, 8, -1, 0, -1, 1'b0, 1'b0, 1'b0);

        // Reset one cycle after the 5th pixel's final beat reaches the input register.
        enable = 1'b1;
        decim  = 1'b0;
        vsync  = 1'b1;
        repeat (4) step();
        vsync = 1'b0;
        repeat (4) step();
        m_addr = 0;
        b      = 0;
        send_line(8, 0, 1'b1, 1'b0, b);
        href = 1'b1;
        din  = 8'h08;
        step();
        din = 8'h09;
        step();
        reset = 1'b1;
        href  = 1'b0;
        step();
        @(negedge PCLK);
        check("midrst_we", 32'(we), 32'd0);
        check("midrst_waddr", 32'(waddr), 32'd0);
        check("midrst_wdata", 32'(wdata), 32'd0);
        check("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_line_err", 32'(line_err), 32'd0);
        check("midrst_pending", 32'(q.size()), 32'd0);
        reset  = 1'b0;
        exp_fc = 0;
        repeat (4) step();
        check("post_rst_busy", 32'(busy), 32'd0);
        run_frame("after_rst", 3, 8, -1, 0, -1, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
